// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, req/ack imem port,
// redirect drain and one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm_o
);

  typedef enum logic [1:0] {
    FETCH,
    BUF,
    DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] skid;
  logic [31:0] skid_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] target;
  logic [31:0] req_addr;
  logic        free;
  logic        unused_low;

  assign target     = {redirect_pc_i[31:2], 2'b00};
  assign unused_low = ^redirect_pc_i[1:0];
  assign free       = !id_valid || !stall_i;

  // DRAIN keeps the abandoned address on the bus until memory acks it
  assign req_addr    = (state == DRAIN) ? drain_addr : pc;
  assign imem_req_o  = (state == FETCH || state == DRAIN) && !rst;
  assign imem_addr_o = req_addr;

  assign id_valid_o = id_valid;
  assign id_pc_o    = id_pc;
  assign id_instr_o = id_instr;
  assign opcode_o   = id_instr[31:26];
  assign rs_o       = id_instr[25:21];
  assign rt_o       = id_instr[20:16];
  assign rd_o       = id_instr[15:11];
  assign shamt_o    = id_instr[10:6];
  assign funct_o    = id_instr[5:0];
  assign imm_o      = id_instr[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      skid       <= NOP_INSTR;
      skid_pc    <= RESET_PC;
      id_valid   <= 1'b0;
      id_pc      <= RESET_PC;
      id_instr   <= NOP_INSTR;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect_i) begin
            pc       <= target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            if (!imem_ack_i) begin
              drain_addr <= pc;
              state      <= DRAIN;
            end
          end else if (imem_ack_i) begin
            pc <= pc + 32'd4;
            if (free) begin
              id_valid <= 1'b1;
              id_pc    <= req_addr;
              id_instr <= imem_rdata_i;
            end else begin
              skid    <= imem_rdata_i;
              skid_pc <= req_addr;
              state   <= BUF;
            end
          end else if (!stall_i) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end
        BUF: begin
          if (redirect_i) begin
            pc       <= target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            state    <= FETCH;
          end else if (!stall_i) begin
            id_valid <= 1'b1;
            id_pc    <= skid_pc;
            id_instr <= skid;
            state    <= FETCH;
          end
        end
        DRAIN: begin
          id_valid <= 1'b0;
          id_instr <= NOP_INSTR;
          if (redirect_i) pc <= target;
          if (imem_ack_i) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
